// File: rtl/ace_snoop_bcast.sv
// ace_snoop_bcast
// Snoop broadcast and response-merge stage. A single AC request from the CCU
// is broadcast to every snooped master except the initiator. Each target's CR
// is ORed into one merged CR for the CCU. If any target transfers data, the
// lowest-indexed such port's CD burst is forwarded and all other bursts are
// drained.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   ac_*_i / ac_ready_o        snoop request from the CCU
//   snp_ac_*                   per-port AC broadcast (shared payload)
//   snp_cr_*                   per-port snoop responses
//   snp_cd_*                   per-port snoop data
//   cr_*                       merged response to the CCU
//   cd_*                       forwarded snoop data to the CCU
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new AC from the CCU
// SNOOP | AC broadcast to targets, collecting their CRs
// RESP  | merged CR presented to the CCU
// DATA  | forwarding one CD burst, draining the others
module ace_snoop_bcast #(
    parameter int unsigned NoPorts   = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdxW      = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ac_valid_i,
    output logic                         ac_ready_o,
    input  logic [AddrWidth-1:0]         ac_addr_i,
    input  logic [3:0]                   ac_snoop_i,
    input  logic [2:0]                   ac_prot_i,
    input  logic [IdxW-1:0]              ac_src_i,
    output logic [NoPorts-1:0]           snp_ac_valid_o,
    input  logic [NoPorts-1:0]           snp_ac_ready_i,
    output logic [AddrWidth-1:0]         snp_ac_addr_o,
    output logic [3:0]                   snp_ac_snoop_o,
    output logic [2:0]                   snp_ac_prot_o,
    input  logic [NoPorts-1:0]           snp_cr_valid_i,
    output logic [NoPorts-1:0]           snp_cr_ready_o,
    input  logic [NoPorts*5-1:0]         snp_cr_resp_i,
    input  logic [NoPorts-1:0]           snp_cd_valid_i,
    output logic [NoPorts-1:0]           snp_cd_ready_o,
    input  logic [NoPorts*DataWidth-1:0] snp_cd_data_i,
    input  logic [NoPorts-1:0]           snp_cd_last_i,
    output logic                         cr_valid_o,
    input  logic                         cr_ready_i,
    output logic [4:0]                   cr_resp_o,
    output logic [IdxW-1:0]              cr_src_o,
    output logic                         cd_valid_o,
    input  logic                         cd_ready_i,
    output logic [DataWidth-1:0]         cd_data_o,
    output logic                         cd_last_o
);

    typedef enum logic [1:0] {IDLE, SNOOP, RESP, DATA} state_e;

    state_e                 state_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [3:0]             snoop_q;
    logic [2:0]             prot_q;
    logic [NoPorts-1:0]     tgt_q;
    logic [NoPorts-1:0]     ac_done_q;
    logic [NoPorts-1:0]     cr_done_q;
    logic [NoPorts-1:0]     dt_q;
    logic [NoPorts-1:0]     cd_done_q;
    logic [4:0]             resp_q;

    logic [NoPorts-1:0]     tgt_d;
    logic [NoPorts-1:0]     ac_hs;
    logic [NoPorts-1:0]     cr_hs;
    logic [NoPorts-1:0]     cd_last_hs;
    logic [NoPorts-1:0]     dt_new;
    logic [4:0]             resp_merge;
    logic [IdxW-1:0]        sel;

    // A source index beyond the port count matches no bit, so nobody is excluded.
    always_comb begin
        tgt_d = '1;
        for (int i = 0; i < NoPorts; i++) begin
            if (int'(ac_src_i) == i) tgt_d[i] = 1'b0;
        end
    end

    // Lowest-indexed port that reported DataTransfer supplies the data.
    always_comb begin
        sel = '0;
        for (int i = NoPorts - 1; i >= 0; i--) begin
            if (dt_q[i]) sel = IdxW'(i);
        end
    end

    assign ac_hs      = snp_ac_valid_o & snp_ac_ready_i;
    assign cr_hs      = snp_cr_ready_o & snp_cr_valid_i;
    assign cd_last_hs = snp_cd_valid_i & snp_cd_ready_o & snp_cd_last_i;

    always_comb begin
        resp_merge = resp_q;
        dt_new     = '0;
        for (int i = 0; i < NoPorts; i++) begin
            if (cr_hs[i]) begin
                resp_merge = resp_merge | snp_cr_resp_i[i*5 +: 5];
                dt_new[i]  = snp_cr_resp_i[i*5];
            end
        end
    end

    assign snp_ac_addr_o  = addr_q;
    assign snp_ac_snoop_o = snoop_q;
    assign snp_ac_prot_o  = prot_q;

    always_comb begin
        ac_ready_o     = 1'b0;
        snp_ac_valid_o = '0;
        snp_cr_ready_o = '0;
        snp_cd_ready_o = '0;
        cr_valid_o     = 1'b0;
        cr_resp_o      = '0;
        cr_src_o       = '0;
        cd_valid_o     = 1'b0;
        cd_data_o      = '0;
        cd_last_o      = 1'b0;
        case (state_q)
            IDLE: ac_ready_o = 1'b1;
            SNOOP: begin
                snp_ac_valid_o = tgt_q & ~ac_done_q;
                snp_cr_ready_o = tgt_q & ac_done_q & ~cr_done_q;
            end
            RESP: begin
                cr_valid_o = 1'b1;
                cr_resp_o  = resp_q;
                cr_src_o   = sel;
            end
            DATA: begin
                // Ports whose burst has completed stop being accepted so a
                // stray beat cannot be swallowed.
                for (int i = 0; i < NoPorts; i++) begin
                    if (dt_q[i] && !cd_done_q[i]) begin
                        snp_cd_ready_o[i] = (int'(sel) == i) ? cd_ready_i : 1'b1;
                    end
                end
                cd_valid_o = snp_cd_valid_i[sel] & ~cd_done_q[sel];
                cd_data_o  = snp_cd_data_i[int'(sel)*DataWidth +: DataWidth];
                cd_last_o  = snp_cd_last_i[sel];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            snoop_q   <= '0;
            prot_q    <= '0;
            tgt_q     <= '0;
            ac_done_q <= '0;
            cr_done_q <= '0;
            dt_q      <= '0;
            cd_done_q <= '0;
            resp_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ac_valid_i) begin
                        addr_q    <= ac_addr_i;
                        snoop_q   <= ac_snoop_i;
                        prot_q    <= ac_prot_i;
                        tgt_q     <= tgt_d;
                        ac_done_q <= '0;
                        cr_done_q <= '0;
                        dt_q      <= '0;
                        cd_done_q <= '0;
                        resp_q    <= '0;
                        state_q   <= SNOOP;
                    end
                end
                SNOOP: begin
                    ac_done_q <= ac_done_q | ac_hs;
                    cr_done_q <= cr_done_q | cr_hs;
                    dt_q      <= dt_q | dt_new;
                    resp_q    <= resp_merge;
                    // Look ahead at this cycle's handshakes so RESP follows the
                    // final CR directly; an empty target set falls through here.
                    if ((cr_done_q | cr_hs) == tgt_q) state_q <= RESP;
                end
                RESP: begin
                    if (cr_ready_i) state_q <= (dt_q != '0) ? DATA : IDLE;
                end
                DATA: begin
                    cd_done_q <= cd_done_q | cd_last_hs;
                    if ((cd_done_q | cd_last_hs) == dt_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_snoop_bcast.sv
module tb_ace_snoop_bcast;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             ac_valid, ac_ready;
    logic [AW-1:0]    ac_addr;
    logic [3:0]       ac_snoop;
    logic [2:0]       ac_prot;
    logic [1:0]       ac_src;
    logic [N-1:0]     snp_ac_valid, snp_ac_ready;
    logic [AW-1:0]    snp_ac_addr;
    logic [3:0]       snp_ac_snoop;
    logic [2:0]       snp_ac_prot;
    logic [N-1:0]     snp_cr_valid, snp_cr_ready;
    logic [N*5-1:0]   snp_cr_resp;
    logic [N-1:0]     snp_cd_valid, snp_cd_ready, snp_cd_last;
    logic [N*DW-1:0]  snp_cd_data;
    logic             cr_valid, cr_ready;
    logic [4:0]       cr_resp;
    logic [1:0]       cr_src;
    logic             cd_valid, cd_ready;
    logic [DW-1:0]    cd_data;
    logic             cd_last;

    logic             s_ac_valid, s_ac_ready;
    logic [AW-1:0]    s_ac_addr;
    logic [3:0]       s_ac_snoop;
    logic [2:0]       s_ac_prot;
    logic [0:0]       s_ac_src;
    logic [0:0]       s_snp_ac_valid, s_snp_ac_ready;
    logic [AW-1:0]    s_snp_ac_addr;
    logic [3:0]       s_snp_ac_snoop;
    logic [2:0]       s_snp_ac_prot;
    logic [0:0]       s_snp_cr_valid, s_snp_cr_ready;
    logic [4:0]       s_snp_cr_resp;
    logic [0:0]       s_snp_cd_valid, s_snp_cd_ready, s_snp_cd_last;
    logic [DW-1:0]    s_snp_cd_data;
    logic             s_cr_valid, s_cr_ready;
    logic [4:0]       s_cr_resp;
    logic [0:0]       s_cr_src;
    logic             s_cd_valid, s_cd_ready;
    logic [DW-1:0]    s_cd_data;
    logic             s_cd_last;

    ace_snoop_bcast #(.NoPorts(N), .AddrWidth(AW), .DataWidth(DW)) u4 (
        .clk_i(clk), .rst_ni(rst_n),
        .ac_valid_i(ac_valid), .ac_ready_o(ac_ready), .ac_addr_i(ac_addr),
        .ac_snoop_i(ac_snoop), .ac_prot_i(ac_prot), .ac_src_i(ac_src),
        .snp_ac_valid_o(snp_ac_valid), .snp_ac_ready_i(snp_ac_ready),
        .snp_ac_addr_o(snp_ac_addr), .snp_ac_snoop_o(snp_ac_snoop), .snp_ac_prot_o(snp_ac_prot),
        .snp_cr_valid_i(snp_cr_valid), .snp_cr_ready_o(snp_cr_ready), .snp_cr_resp_i(snp_cr_resp),
        .snp_cd_valid_i(snp_cd_valid), .snp_cd_ready_o(snp_cd_ready),
        .snp_cd_data_i(snp_cd_data), .snp_cd_last_i(snp_cd_last),
        .cr_valid_o(cr_valid), .cr_ready_i(cr_ready), .cr_resp_o(cr_resp), .cr_src_o(cr_src),
        .cd_valid_o(cd_valid), .cd_ready_i(cd_ready), .cd_data_o(cd_data), .cd_last_o(cd_last)
    );

    ace_snoop_bcast #(.NoPorts(1), .AddrWidth(AW), .DataWidth(DW)) u1 (
        .clk_i(clk), .rst_ni(rst_n),
        .ac_valid_i(s_ac_valid), .ac_ready_o(s_ac_ready), .ac_addr_i(s_ac_addr),
        .ac_snoop_i(s_ac_snoop), .ac_prot_i(s_ac_prot), .ac_src_i(s_ac_src),
        .snp_ac_valid_o(s_snp_ac_valid), .snp_ac_ready_i(s_snp_ac_ready),
        .snp_ac_addr_o(s_snp_ac_addr), .snp_ac_snoop_o(s_snp_ac_snoop), .snp_ac_prot_o(s_snp_ac_prot),
        .snp_cr_valid_i(s_snp_cr_valid), .snp_cr_ready_o(s_snp_cr_ready), .snp_cr_resp_i(s_snp_cr_resp),
        .snp_cd_valid_i(s_snp_cd_valid), .snp_cd_ready_o(s_snp_cd_ready),
        .snp_cd_data_i(s_snp_cd_data), .snp_cd_last_i(s_snp_cd_last),
        .cr_valid_o(s_cr_valid), .cr_ready_i(s_cr_ready), .cr_resp_o(s_cr_resp), .cr_src_o(s_cr_src),
        .cd_valid_o(s_cd_valid), .cd_ready_i(s_cd_ready), .cd_data_o(s_cd_data), .cd_last_o(s_cd_last)
    );

    int nchk = 0;
    int nerr = 0;

    // Transaction description
    int            t_src;
    logic [AW-1:0] t_addr;
    logic [3:0]    t_snoop;
    logic [2:0]    t_prot;
    logic [4:0]    t_resp [N];
    int            t_beats [N];
    logic [DW-1:0] t_data [N][4];
    int            ac_dly [N];
    int            cr_wait [N];
    bit            cd_toggle, cd_hold0;

    // Transaction progress as observed by the bench
    bit            accepted, merged_taken;
    int            cyc, launch_dly, fwd_cnt;
    int            ac_cnt [N];
    bit            cr_taken [N];
    int            cd_idx [N];
    logic [4:0]    cap_resp;
    logic [1:0]    cap_src;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit is_tgt(int p);
        return p != t_src;
    endfunction

    function automatic bit has_dt(int p);
        return is_tgt(p) && t_resp[p][0];
    endfunction

    function automatic logic [4:0] model_resp();
        logic [4:0] r = '0;
        for (int p = 0; p < N; p++) if (is_tgt(p)) r = r | t_resp[p];
        return r;
    endfunction

    function automatic int model_src();
        for (int p = 0; p < N; p++) if (has_dt(p)) return p;
        return 0;
    endfunction

    function automatic bit any_dt();
        for (int p = 0; p < N; p++) if (has_dt(p)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit all_cr();
        for (int p = 0; p < N; p++) if (is_tgt(p) && !cr_taken[p]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit txn_done();
        if (!merged_taken) return 1'b0;
        for (int p = 0; p < N; p++) if (has_dt(p) && cd_idx[p] < t_beats[p]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_quiet();
        t_addr = $urandom; t_snoop = 4'($urandom); t_prot = 3'($urandom);
        cd_toggle = 1'b0; cd_hold0 = 1'b0;
        for (int p = 0; p < N; p++) begin
            t_resp[p] = '0; t_beats[p] = 1; ac_dly[p] = 0; cr_wait[p] = 0;
            for (int b = 0; b < 4; b++) t_data[p][b] = $urandom;
        end
    endtask

    task automatic set_random();
        set_quiet();
        t_src = $urandom_range(0, N-1);
        for (int p = 0; p < N; p++) begin
            t_resp[p]  = 5'($urandom_range(0, 31));
            t_beats[p] = $urandom_range(1, 4);
            ac_dly[p]  = $urandom_range(0, 6);
            cr_wait[p] = $urandom_range(0, 5);
        end
    endtask

    task automatic clear_progress();
        accepted = 1'b0; merged_taken = 1'b0; cyc = 0; fwd_cnt = 0;
        launch_dly = $urandom_range(0, 2);
        cap_resp = '0; cap_src = '0;
        for (int p = 0; p < N; p++) begin
            ac_cnt[p] = 0; cr_taken[p] = 1'b0; cd_idx[p] = 0;
        end
    endtask

    // Drive all DUT inputs for the coming cycle from the bench's view of progress.
    task automatic drive();
        if (!accepted && launch_dly == 0) begin
            ac_valid = 1'b1; ac_addr = t_addr; ac_snoop = t_snoop; ac_prot = t_prot;
            ac_src = 2'(t_src);
        end else begin
            ac_valid = 1'b0; ac_addr = $urandom; ac_snoop = 4'($urandom); ac_prot = 3'($urandom);
            ac_src = 2'($urandom);
        end
        if (!accepted && launch_dly > 0) launch_dly--;
        for (int p = 0; p < N; p++) begin
            snp_ac_ready[p] = accepted ? (cyc >= ac_dly[p]) : 1'($urandom);
            if (ac_cnt[p] > 0 && !cr_taken[p] && cr_wait[p] == 0) begin
                snp_cr_valid[p] = 1'b1; snp_cr_resp[p*5 +: 5] = t_resp[p];
            end else begin
                snp_cr_valid[p] = 1'b0; snp_cr_resp[p*5 +: 5] = 5'($urandom);
            end
            if (ac_cnt[p] > 0 && !cr_taken[p] && cr_wait[p] > 0) cr_wait[p]--;
            if (has_dt(p) && cr_taken[p] && cd_idx[p] < t_beats[p] && $urandom_range(0, 3) != 0) begin
                snp_cd_valid[p] = 1'b1;
                snp_cd_data[p*DW +: DW] = t_data[p][cd_idx[p]];
                snp_cd_last[p] = (cd_idx[p] == t_beats[p] - 1);
            end else begin
                snp_cd_valid[p] = 1'b0;
                snp_cd_data[p*DW +: DW] = $urandom;
                snp_cd_last[p] = 1'($urandom);
            end
        end
        cr_ready = 1'($urandom);
        if (cd_hold0)       cd_ready = 1'b0;
        else if (cd_toggle) cd_ready = ~cd_ready;
        else                cd_ready = 1'($urandom);
    endtask

    // Compare every output against the transaction model, then advance the model.
    task automatic check_and_update();
        logic [N-1:0] e_acv, e_crr, e_cdr;
        bit e_crv, e_cdv, data_ph;
        int sel;
        sel = model_src();
        data_ph = merged_taken && any_dt() && !txn_done();
        for (int p = 0; p < N; p++) begin
            e_acv[p] = accepted && is_tgt(p) && ac_cnt[p] == 0;
            e_crr[p] = accepted && is_tgt(p) && ac_cnt[p] > 0 && !cr_taken[p];
            e_cdr[p] = (data_ph && has_dt(p) && cd_idx[p] < t_beats[p]) ? ((p == sel) ? cd_ready : 1'b1) : 1'b0;
        end
        e_crv = accepted && all_cr() && !merged_taken;
        e_cdv = data_ph && snp_cd_valid[sel] && cd_idx[sel] < t_beats[sel];

        chk("ac_ready", ac_ready, !accepted);
        chk("snp_ac_valid", snp_ac_valid, e_acv);
        chk("snp_cr_ready", snp_cr_ready, e_crr);
        chk("snp_cd_ready", snp_cd_ready, e_cdr);
        chk("cr_valid", cr_valid, e_crv);
        chk("cd_valid", cd_valid, e_cdv);
        if (|e_acv) begin
            chk("snp_ac_addr", snp_ac_addr, t_addr);
            chk("snp_ac_snoop", snp_ac_snoop, t_snoop);
            chk("snp_ac_prot", snp_ac_prot, t_prot);
        end
        if (e_crv) begin
            chk("cr_resp", cr_resp, model_resp());
            chk("cr_src", cr_src, sel);
        end else begin
            chk("cr_src idle", cr_src, 0);
        end
        if (e_cdv) begin
            chk("cd_data", cd_data, t_data[sel][cd_idx[sel]]);
            chk("cd_last", cd_last, cd_idx[sel] == t_beats[sel] - 1);
        end

        if (accepted) cyc++;
        if (!accepted && ac_valid) begin
            accepted = 1'b1; cyc = 0;
        end
        for (int p = 0; p < N; p++) begin
            if (e_acv[p] && snp_ac_ready[p]) ac_cnt[p]++;
            if (e_crr[p] && snp_cr_valid[p]) cr_taken[p] = 1'b1;
            if (e_cdr[p] && snp_cd_valid[p]) cd_idx[p]++;
        end
        if (e_cdv && cd_ready) fwd_cnt++;
        if (e_crv && cr_ready) begin
            merged_taken = 1'b1; cap_resp = cr_resp; cap_src = cr_src;
        end
    endtask

    task automatic run_txn(input bit stop_in_data);
        clear_progress();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            drive();
            @(negedge clk);
            check_and_update();
            if (stop_in_data && merged_taken && any_dt()) return;
            if (accepted && txn_done()) return;
        end
        nchk++; nerr++;
        $display("FAIL txn_timeout: got no completion expected completion within 400 cycles");
    endtask

    initial begin
        ac_valid = 0; ac_addr = '0; ac_snoop = '0; ac_prot = '0; ac_src = '0;
        snp_ac_ready = '0; snp_cr_valid = '0; snp_cr_resp = '0;
        snp_cd_valid = '0; snp_cd_data = '0; snp_cd_last = '0;
        cr_ready = 0; cd_ready = 0;
        s_ac_valid = 0; s_ac_addr = '0; s_ac_snoop = '0; s_ac_prot = '0; s_ac_src = '0;
        s_snp_ac_ready = '0; s_snp_cr_valid = '0; s_snp_cr_resp = '0;
        s_snp_cd_valid = '0; s_snp_cd_data = '0; s_snp_cd_last = '0;
        s_cr_ready = 0; s_cd_ready = 0;
        t_src = 0;
        set_quiet();
        clear_progress();

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst ac_ready", ac_ready, 1);
        chk("rst snp_ac_valid", snp_ac_valid, 0);
        chk("rst snp_cr_ready", snp_cr_ready, 0);
        chk("rst snp_cd_ready", snp_cd_ready, 0);
        chk("rst cr_valid", cr_valid, 0);
        chk("rst cr_src", cr_src, 0);
        chk("rst cd_valid", cd_valid, 0);
        rst_n = 1'b1;

        // Shared-only responses, no data
        set_quiet(); t_src = 1;
        t_resp[0] = 5'b01000; t_resp[2] = 5'b01000; t_resp[3] = 5'b01000;
        run_txn(0);
        chk("d1 cr_resp", cap_resp, 5'b01000);
        chk("d1 cr_src", cap_src, 0);
        chk("d1 fwd beats", fwd_cnt, 0);

        // Staggered AC ready, CRs in reverse order
        set_quiet(); t_src = 1;
        t_resp[0] = 5'b01000; t_resp[2] = 5'b00100; t_resp[3] = 5'b00000;
        ac_dly[0] = 0; ac_dly[2] = 2; ac_dly[3] = 5;
        cr_wait[0] = 10; cr_wait[2] = 6; cr_wait[3] = 0;
        run_txn(0);
        chk("d2 cr_resp", cap_resp, 5'b01100);
        chk("d2 cr_src", cap_src, 0);

        // Two data sources, port 3 answers first, toggling cd_ready
        set_quiet(); t_src = 1; cd_toggle = 1'b1;
        t_resp[2] = 5'b00001; t_resp[3] = 5'b00001;
        t_beats[2] = 4; t_beats[3] = 4;
        cr_wait[2] = 5; cr_wait[3] = 0;
        run_txn(0);
        chk("d3 cr_src", cap_src, 2);
        chk("d3 cr_resp", cap_resp, 5'b00001);
        chk("d3 fwd beats", fwd_cnt, 4);

        // Merged response across ports
        set_quiet(); t_src = 1;
        t_resp[0] = 5'b00110; t_resp[3] = 5'b10001; t_beats[3] = 2;
        chk("model resp pin", model_resp(), 5'b10111);
        chk("model src pin", model_src(), 3);
        run_txn(0);
        chk("d4 cr_resp", cap_resp, 5'b10111);
        chk("d4 cr_src", cap_src, 3);
        chk("d4 fwd beats", fwd_cnt, 2);

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            set_random();
            run_txn(0);
            if (merged_taken && any_dt()) chk("rand fwd beats", fwd_cnt, t_beats[model_src()]);
        end

        // Asynchronous reset while in DATA
        set_quiet(); t_src = 0; cd_hold0 = 1'b1;
        t_resp[2] = 5'b00001; t_resp[3] = 5'b00001; t_beats[2] = 4; t_beats[3] = 4;
        run_txn(1);
        @(posedge clk); #2;
        snp_cd_valid = 4'b1100;
        rst_n = 1'b0;
        #1;
        chk("arst ac_ready", ac_ready, 1);
        chk("arst snp_ac_valid", snp_ac_valid, 0);
        chk("arst snp_cr_ready", snp_cr_ready, 0);
        chk("arst snp_cd_ready", snp_cd_ready, 0);
        chk("arst cr_valid", cr_valid, 0);
        chk("arst cd_valid", cd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_quiet(); t_src = 2;
        t_resp[0] = 5'b01000; t_resp[1] = 5'b00001; t_beats[1] = 3;
        run_txn(0);
        chk("post-rst cr_resp", cap_resp, 5'b01001);
        chk("post-rst cr_src", cap_src, 1);
        chk("post-rst fwd beats", fwd_cnt, 3);

        // Single-port instance with the only port as source: empty target set
        @(posedge clk); #1;
        s_ac_valid = 1'b1; s_ac_src = 1'b0; s_cr_ready = 1'b1; s_snp_ac_ready = 1'b1;
        @(negedge clk);
        chk("n1 ac_ready T", s_ac_ready, 1);
        @(posedge clk); #1;
        s_ac_valid = 1'b0;
        @(negedge clk);
        chk("n1 cr_valid T+1", s_cr_valid, 0);
        chk("n1 snp_ac_valid T+1", s_snp_ac_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n1 cr_valid T+2", s_cr_valid, 1);
        chk("n1 cr_resp T+2", s_cr_resp, 0);
        chk("n1 cr_src T+2", s_cr_src, 0);
        chk("n1 snp_ac_valid T+2", s_snp_ac_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n1 ac_ready T+3", s_ac_ready, 1);
        chk("n1 cr_valid T+3", s_cr_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/ace_snoop_bcast.md
# ace_snoop_bcast

Snoop broadcast and response-merge stage between the CCU snoop FSM and the per-master `SNOOP_BUS` ports. It accepts one snoop request (AC) from the CCU and broadcasts it to every cached master except the initiator. It collects each target's snoop response (CR) and merges them into a single CR back to the CCU. If any target returns data, it forwards one snoop data (CD) burst and discards the others.

## Interface
- `NoPorts`, 2: number of snooped masters (≥1).
- `AddrWidth`, 64: AC address width.
- `DataWidth`, 64: CD data width.
- `IdxW`, `idx_width(NoPorts)`: port index width (derived; do not override).
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active-low.
- `ac_valid_i` in 1: snoop request from CCU valid.
- `ac_ready_o` out 1: snoop request accepted.
- `ac_addr_i` in AddrWidth: snoop address.
- `ac_snoop_i` in 4: ACSNOOP.
- `ac_prot_i` in 3: ACPROT.
- `ac_src_i` in IdxW: initiating port, excluded from broadcast; a value ≥ NoPorts excludes nobody.
- `snp_ac_valid_o` out NoPorts: per-port AC valid.
- `snp_ac_ready_i` in NoPorts: per-port AC ready.
- `snp_ac_addr_o` out AddrWidth: shared AC address.
- `snp_ac_snoop_o` out 4: shared ACSNOOP.
- `snp_ac_prot_o` out 3: shared ACPROT.
- `snp_cr_valid_i` in NoPorts: per-port CR valid.
- `snp_cr_ready_o` out NoPorts: per-port CR ready.
- `snp_cr_resp_i` in NoPorts*5: per-port CRRESP, with bit 0 DataTransfer, 1 Error, 2 PassDirty, 3 IsShared, 4 WasUnique.
- `snp_cd_valid_i` in NoPorts: per-port CD valid.
- `snp_cd_ready_o` out NoPorts: per-port CD ready.
- `snp_cd_data_i` in NoPorts*DataWidth: per-port CD data.
- `snp_cd_last_i` in NoPorts: per-port CD last.
- `cr_valid_o` out 1: merged response valid.
- `cr_ready_i` in 1: merged response accepted.
- `cr_resp_o` out 5: merged CRRESP.
- `cr_src_o` out IdxW: port supplying data; 0 if none.
- `cd_valid_o` out 1: forwarded data valid.
- `cd_ready_i` in 1: forwarded data accepted.
- `cd_data_o` out DataWidth: forwarded data.
- `cd_last_o` out 1: forwarded last beat.

## Operation
- FSM states: IDLE, SNOOP, RESP, DATA.
- **IDLE**
  - `ac_ready_o`=1.
  - On AC handshake, register addr/snoop/prot/src.
  - Compute target mask `tgt` = all ports minus `ac_src_i`.
  - Clear `ac_done`, `cr_done`, `dt`, `cd_done` and the merged response; go to SNOOP.
- **SNOOP**
  - `snp_ac_valid_o[i]` = `tgt[i] & !ac_done[i]`.
  - `ac_done[i]` sets on the per-port handshake; ports complete independently and in any order.
  - `snp_cr_ready_o[i]` = `tgt[i] & ac_done[i] & !cr_done[i]`.
  - On a CR handshake: set `cr_done[i]`, OR the response into the merged response, and set `dt[i]` if bit 0 is set.
  - When `cr_done == tgt`, go to RESP.
  - An empty `tgt` (NoPorts=1 with the source excluded) moves to RESP on the next cycle with response 0.
- **RESP**
  - `cr_valid_o`=1; `cr_resp_o` is the OR of all target responses.
  - `cr_src_o` = lowest index with `dt` set (0 if none).
  - On `cr_ready_i`, go to DATA if `dt` is nonzero, else IDLE.
- **DATA**
  - The selected port `sel` = `cr_src_o` is passed through combinationally: `cd_valid_o`=`snp_cd_valid_i[sel]`, `snp_cd_ready_o[sel]`=`cd_ready_i`, and data/last are muxed from `sel`.
  - Every other port with `dt` set gets `snp_cd_ready_o`=1; its beats are discarded.
  - `cd_done[i]` sets on a last-beat handshake.
  - When `cd_done == dt`, go to IDLE.
- CD beats arriving before DATA are not accepted: `snp_cd_ready_o`=0 outside DATA.
- Outputs in states where they are not driven above are 0; `snp_ac_*_o` payload holds its registered value.

## Timing
- Reset: state IDLE, all registers 0, every valid/ready output 0 except `ac_ready_o`=1, `cr_src_o`=0.
- AC accepted in cycle T: `snp_ac_valid_o` is asserted in T+1.
- Minimum AC-to-`cr_valid_o` latency is 3 cycles (AC out in T+1, CR accepted in T+2, RESP in T+3).
- A new AC can be accepted the cycle after the final CR or CD handshake; `ac_ready_o` is asserted in that cycle.
- AC valid is held per port until that port's ready; no combinational path from `snp_ac_ready_i` to `snp_ac_valid_o` in the same port.
- CD path latency is 0 (combinational forward).
- CR and AC handshakes on different ports in the same cycle are all taken.
- Asynchronous reset mid-transaction returns to IDLE immediately; partial bursts are dropped.

## Test plan
- NoPorts=4, src=1, all targets respond CR=5'b01000 with no data -> AC reaches ports 0, 2, 3 only; single `cr_resp_o`=5'b01000, `cr_src_o`=0, no CD; `ac_ready_o` high again afterwards.
- Target ports assert `snp_ac_ready_i` in cycles 1, 3, 6 (staggered) and CRs arrive in reverse order -> exactly one AC handshake per target; merged CR only after the third CR.
- Ports 2 and 3 both return DataTransfer with 4-beat CD (port 3 responds first), `cd_ready_i` toggling every cycle -> `cr_src_o`=2; 4 port-2 beats forwarded in order with `cd_last_o` on beat 4; port-3 beats drained; return to IDLE.
- Port 0 returns CR=5'b00110 and port 3 returns CR=5'b10001 with data -> `cr_resp_o`=5'b10111, `cr_src_o`=3.
- NoPorts=1, src=0 -> `cr_valid_o` at T+2 with `cr_resp_o`=0, no `snp_ac_valid_o`.
- Assert `rst_ni`=0 during the DATA phase -> all valids 0 and `ac_ready_o`=1 asynchronously; a fresh snoop after reset completes normally.
